// File: rtl/image_deserializer_pkg.sv
// Shared image geometry, frame type and FSM states
// for the image deserializer.
package image_deserializer_pkg;

  localparam int HEIGHT        = 28;
  localparam int LENGTH        = 28;
  localparam int BEAT_W        = 4;
  localparam int BEATS_PER_ROW = LENGTH / BEAT_W;
  localparam int ROW_W         = $clog2(HEIGHT);
  localparam int COL_W         = $clog2(BEATS_PER_ROW);

  typedef logic [HEIGHT-1:0][LENGTH-1:0] image_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

endpackage

// File: rtl/image_deserializer_popcount.sv
// Combinational popcount of one input beat.
// Only present when IMG_POPCOUNT_EN is defined.
`ifdef IMG_POPCOUNT_EN
module beat_popcount #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  pix,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++)
      count = count + CW'(pix[i]);
  end

endmodule
`endif

// File: rtl/image_deserializer.sv
// Beat-stream to whole-frame deserializer with a one-frame skid.
// Define IMG_POPCOUNT_EN to produce frame_sum alongside out_image.
module image_deserializer
  import image_deserializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [BEAT_W-1:0] in_pix,
  output logic              out_valid,
  input  logic              out_ready,
  output image_t            out_image,
  output logic [31:0]       frame_sum,
  output logic              sof_err
);

  if (LENGTH % BEAT_W != 0) begin : g_bad_geom
    $error("LENGTH must be a multiple of BEAT_W");
  end

  state_t            state;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col_beat;
  image_t            asm_buf;
  image_t            asm_next;
  logic              accept;
  logic              start;
  logic              take;
  logic              last;
  logic              drain;
  logic              out_free;
  logic              load;
  logic [ROW_W-1:0]  wr_row;
  logic [COL_W-1:0]  wr_col;

  assign in_ready = (state != FULL);
  assign accept   = in_valid && in_ready;
  assign start    = accept && in_sof;
  assign take     = accept && (in_sof || state == FILL);
  assign wr_row   = start ? '0 : row;
  assign wr_col   = start ? '0 : col_beat;
  assign last     = take
                 && wr_row == ROW_W'(HEIGHT - 1)
                 && wr_col == COL_W'(BEATS_PER_ROW - 1);
  assign drain    = out_valid && out_ready;
  assign out_free = !out_valid || out_ready;
  assign load     = (last && out_free)
                 || (state == FULL && drain);

  // The beat landing this cycle is merged so a frame can
  // be handed over on the same edge its last beat arrives.
  always_comb begin
    asm_next = asm_buf;
    if (take)
      asm_next[wr_row][int'(wr_col)*BEAT_W +: BEAT_W] = in_pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      col_beat  <= '0;
      asm_buf   <= '0;
      out_image <= '0;
      out_valid <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      asm_buf <= asm_next;
      if (take) begin
        if (last) begin
          row      <= '0;
          col_beat <= '0;
        end else if (wr_col == COL_W'(BEATS_PER_ROW - 1)) begin
          row      <= wr_row + 1'b1;
          col_beat <= '0;
        end else begin
          row      <= wr_row;
          col_beat <= wr_col + 1'b1;
        end
      end
      if (start && state == FILL)
        sof_err <= 1'b1;
      unique case (state)
        FULL: if (drain) state <= IDLE;
        default: begin
          if (last)
            state <= out_free ? IDLE : FULL;
          else if (start)
            state <= FILL;
        end
      endcase
      if (load) begin
        out_image <= asm_next;
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef IMG_POPCOUNT_EN
  localparam int CW = $clog2(BEAT_W + 1);

  logic [CW-1:0] beat_cnt;
  logic [31:0]   acc;
  logic [31:0]   acc_next;

  beat_popcount #(.W(BEAT_W), .CW(CW)) u_popcount (
    .pix   (in_pix),
    .count (beat_cnt)
  );

  assign acc_next = (start ? 32'd0 : acc) + 32'(beat_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      frame_sum <= '0;
    end else begin
      if (take)
        acc <= acc_next;
      if (load)
        frame_sum <= take ? acc_next : acc;
    end
  end
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_image_deserializer.sv
// Randomized self-checking bench for image_deserializer
// against a frame-level reference model.
module tb_image_deserializer;
  import image_deserializer_pkg::*;

  localparam int NBEATS = HEIGHT * BEATS_PER_ROW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_sof = 1'b0;
  logic [BEAT_W-1:0] in_pix = '0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              sof_err;
  image_t            out_image;
  logic [31:0]       frame_sum;

  always #5 clk = ~clk;

  image_deserializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_pix    (in_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_image (out_image),
    .frame_sum (frame_sum),
    .sof_err   (sof_err)
  );

  int total = 0;
  int passed = 0;

  // Reference model: frame under assembly, a parked frame, the shown frame
  image_t m_asm, m_out, m_pimg;
  bit     m_active, m_pend, m_ov, m_err;
  int     m_idx;
  int     cyc = 0;
  bit     log_en = 0;
  bit     prev_ov = 0;
  int     rise_q[$];
  bit     rnd_ready = 0;
  int     idle_pct = 0;

  function automatic int ones(image_t img);
    int n = 0;
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < LENGTH; c++)
        n += int'(img[r][c]);
    return n;
  endfunction

  function automatic int exp_sum();
`ifdef IMG_POPCOUNT_EN
    return ones(m_out);
`else
    return 0;
`endif
  endfunction

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_img(string name, image_t exp);
    int bad = 0;
    total++;
    if (out_image == exp) passed++;
    else begin
      for (int r = HEIGHT - 1; r >= 0; r--)
        if (out_image[r] != exp[r]) bad = r;
      $display("FAIL %s: row %0d got %h expected %h",
               name, bad, out_image[bad], exp[bad]);
    end
  endtask

  task automatic model_reset();
    m_asm = '0; m_out = '0; m_pimg = '0;
    m_active = 0; m_pend = 0; m_ov = 0; m_err = 0;
    m_idx = 0;
  endtask

  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_pend);
    chk("out_valid", out_valid, m_ov);
    chk("sof_err", sof_err, m_err);
    chk_img("out_image", m_out);
    chk("frame_sum", frame_sum, exp_sum());
  end

  task automatic step();
    bit acc, drain, free;
    int pos;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    if (rst_n) begin
      acc   = in_valid && !m_pend;
      drain = m_ov && out_ready;
      free  = !m_ov || out_ready;
      if (drain) begin
        if (m_pend) begin
          m_out  = m_pimg;
          m_pend = 0;
        end else m_ov = 0;
      end
      if (acc && (in_sof || m_active)) begin
        if (in_sof) begin
          if (m_active) m_err = 1;
          m_active = 1;
          m_idx = 0;
        end
        for (int b = 0; b < BEAT_W; b++) begin
          pos = m_idx * BEAT_W + b;
          m_asm[pos / LENGTH][pos % LENGTH] = in_pix[b];
        end
        m_idx++;
        if (m_idx == NBEATS) begin
          m_active = 0;
          if (free) begin
            m_out = m_asm;
            m_ov  = 1;
          end else begin
            m_pimg = m_asm;
            m_pend = 1;
          end
        end
      end
    end
    cyc++;
    #1;
    if (log_en && out_valid && !prev_ov) rise_q.push_back(cyc);
    prev_ov = out_valid;
  endtask

  task automatic send_beat(bit sof, logic [BEAT_W-1:0] pix);
    bit took;
    int guard = 0;
    if (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) begin
      in_valid = 0;
      step();
    end
    in_valid = 1; in_sof = sof; in_pix = pix;
    forever begin
      took = !m_pend;
      step();
      if (took) break;
      guard++;
      if (guard > 2000) begin
        total++;
        $display("FAIL beat_timeout: got stalled expected accepted");
        break;
      end
    end
    in_sof = 0;
  endtask

  task automatic send_frame(int kind);
    logic [BEAT_W-1:0] p;
    for (int i = 0; i < NBEATS; i++) begin
      case (kind)
        1: p = 4'b0101;
        2: p = '1;
        3: p = '0;
        default: p = BEAT_W'($urandom);
      endcase
      send_beat(i == 0, p);
    end
  endtask

  task automatic async_reset();
    image_t zero_img = '0;
    in_valid = 0;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_frame_sum", frame_sum, 0);
    chk_img("rst_out_image", zero_img);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    image_t a_img;
    image_t all1 = '1;
    image_t zero_img = '0;
    model_reset();
    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_in_ready", in_ready, 1);
    chk_img("init_out_image", zero_img);
    @(posedge clk);
    #1;
    rst_n = 1;
    step();

    // checkerboard
    out_ready = 1;
    send_frame(1);
    in_valid = 0;
    chk("cb_valid", out_valid, 1);
    chk("cb_row0", out_image[0], 28'h5555555);
    chk("cb_row27", out_image[HEIGHT-1], 28'h5555555);
    chk("cb_model_sum", ones(m_out), 392);
`ifdef IMG_POPCOUNT_EN
    chk("cb_sum", frame_sum, 392);
`endif
    step();
    chk("cb_valid_fall", out_valid, 0);

    // consumer stall
    out_ready = 0;
    send_frame(0);
    a_img = m_out;
    send_frame(0);
    in_valid = 0;
    chk("stall_in_ready", in_ready, 0);
    chk_img("stall_holds_a", a_img);
    repeat (3) step();
    chk_img("stall_still_a", a_img);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("stall_in_ready_back", in_ready, 1);
    chk("stall_valid_b", out_valid, 1);
    step();

    // mid-frame restart
    out_ready = 1;
    send_beat(1, BEAT_W'($urandom));
    for (int i = 0; i < 48; i++) send_beat(0, BEAT_W'($urandom));
    for (int i = 0; i < NBEATS; i++) send_beat(i == 0, '1);
    in_valid = 0;
    chk("restart_sof_err", sof_err, 1);
    chk_img("restart_ones", all1);
    chk("restart_model_sum", ones(m_out), 784);
`ifdef IMG_POPCOUNT_EN
    chk("restart_sum", frame_sum, 784);
`endif
    step();

    // stray beats before sof
    for (int i = 0; i < 10; i++) send_beat(0, BEAT_W'($urandom));
    send_frame(3);
    in_valid = 0;
    chk_img("presof_zero", zero_img);
    chk("presof_model_sum", ones(m_out), 0);
    chk("presof_sum", frame_sum, 0);
    step();

    // back-to-back
    rise_q.delete();
    log_en = 1;
    for (int f = 0; f < 3; f++) send_frame(0);
    in_valid = 0;
    step();
    log_en = 0;
    chk("b2b_pulses", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      chk("b2b_gap1", rise_q[1] - rise_q[0], NBEATS);
      chk("b2b_gap2", rise_q[2] - rise_q[1], NBEATS);
    end

    // async reset mid-FILL
    send_beat(1, BEAT_W'($urandom));
    for (int i = 0; i < 29; i++) send_beat(0, BEAT_W'($urandom));
    async_reset();
    // async reset in FULL
    out_ready = 0;
    send_frame(0);
    send_frame(0);
    chk("full_in_ready", in_ready, 0);
    async_reset();
    out_ready = 1;
    send_frame(0);
    in_valid = 0;
    chk("post_rst_valid", out_valid, 1);
    step();

    // randomized flow control
    rnd_ready = 1;
    idle_pct = 30;
    for (int f = 0; f < 4; f++) send_frame(0);
    in_valid = 0;
    rnd_ready = 0;
    idle_pct = 0;
    out_ready = 1;
    repeat (4) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
